// File: rtl/opb_reg_pkg.sv
// Shared definitions for the OPB slave register blocks: transfer FSM
// states, register word offsets within the slave window, and the byte-lane
// merge used on partial writes.
package opb_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } opb_state_e;

  localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFF_WCOUNT = 32'h0000_0004;

  // be[3] owns bits [31:24] (OPB byte lane 0), be[0] owns bits [7:0].
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/opb_slave_decode.sv
// Single-beat OPB slave front end: window decode, request capture and the
// IDLE/ACK/HOLD transfer sequencer that drives the acknowledge.
//
// Handshake: i_select is the master's request and stays asserted until it
// sees o_xfer_ack. A hit in IDLE is captured at the end of that cycle and
// acked for exactly the next cycle; HOLD then gives one turnaround cycle so
// a still-asserted select is not double-counted. Select changes during ACK
// or HOLD are ignored. Out-of-window selects are never acked.
module opb_slave_decode
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0108_EC00,
  parameter logic [31:0] C_HIGHADDR = 32'h0108_ECFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_abus,
  input  logic [31:0] i_dbus,
  input  logic [3:0]  i_be,
  input  logic        i_rnw,
  input  logic        i_select,
  output logic        o_xfer_ack,
  output logic        o_rnw,
  output logic [3:0]  o_be,
  output logic [31:0] o_data,
  output logic [31:0] o_offset,
  output opb_state_e  o_state
);

  opb_state_e  r_state;
  logic        r_ack;
  logic        r_rnw;
  logic [3:0]  r_be;
  logic [31:0] r_data;
  logic [31:0] r_offset;
  logic        w_hit;
  logic [31:0] w_offset;

  assign w_hit    = i_select && (i_abus >= C_BASEADDR) && (i_abus <= C_HIGHADDR);
  assign w_offset = i_abus - C_BASEADDR;

  // Transfer sequencer with request capture and registered acknowledge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_ack    <= 1'b0;
      r_rnw    <= 1'b0;
      r_be     <= 4'b0000;
      r_data   <= 32'h0;
      r_offset <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= 1'b0;
          if (w_hit) begin
            r_state  <= ACK;
            r_ack    <= 1'b1;
            r_rnw    <= i_rnw;
            r_be     <= i_be;
            r_data   <= i_dbus;
            r_offset <= {w_offset[31:2], 2'b00};
          end
        end
        ACK: begin
          r_state <= HOLD;
          r_ack   <= 1'b0;
        end
        HOLD: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign o_xfer_ack = r_ack;
  assign o_rnw      = r_rnw;
  assign o_be       = r_be;
  assign o_data     = r_data;
  assign o_offset   = r_offset;
  assign o_state    = r_state;

endmodule

// File: rtl/opb_register_ppc2simulink_sync.sv
// PPC-to-user control register on OPB: software writes a 32-bit control
// word (byte-enable merged), user logic sees it on user_data_out with a
// one-cycle update strobe; a read-only counter tracks effective writes.
module opb_register_ppc2simulink_sync
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0108_EC00,
  parameter logic [31:0] C_HIGHADDR   = 32'h0108_ECFF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5",
  parameter logic [31:0] C_DEFAULT    = 32'h0000_0000
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic [31:0] user_data_out,
  output logic        user_data_update
);

  logic        w_ack;
  logic        w_rnw;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_offset;
  logic        w_wr_eff;
  logic [31:0] w_rdata;
  opb_state_e  w_unused_state;
  logic        w_unused_seq;

  logic [31:0] r_user_data;
  logic [31:0] r_wcount;
  logic        r_update;

  // Bit 0 of the big-endian OPB buses lands on bit 31 of the local vectors.
  opb_slave_decode #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_decode (
    .i_clk      (OPB_Clk),
    .i_rst      (OPB_Rst),
    .i_abus     (OPB_ABus),
    .i_dbus     (OPB_DBus),
    .i_be       (OPB_BE),
    .i_rnw      (OPB_RNW),
    .i_select   (OPB_select),
    .o_xfer_ack (w_ack),
    .o_rnw      (w_rnw),
    .o_be       (w_be),
    .o_data     (w_wdata),
    .o_offset   (w_offset),
    .o_state    (w_unused_state)
  );

  assign w_unused_seq = OPB_seqAddr;

  // A DATA write with no byte lanes enabled is acked but changes nothing.
  assign w_wr_eff = w_ack && !w_rnw && (w_offset == OFF_DATA) && (w_be != 4'b0000);

  // Control word, effective-write counter and update strobe.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_user_data <= C_DEFAULT;
      r_wcount    <= 32'h0;
      r_update    <= 1'b0;
    end else begin
      r_update <= w_wr_eff;
      if (w_wr_eff) begin
        r_user_data <= be_merge(r_user_data, w_wdata, w_be);
        r_wcount    <= r_wcount + 32'd1;
      end
    end
  end

  // Read mux; the bus is driven only during the ack of a read.
  always_comb begin
    w_rdata = 32'h0;
    if (w_ack && w_rnw) begin
      case (w_offset)
        OFF_DATA:   w_rdata = r_user_data;
        OFF_WCOUNT: w_rdata = r_wcount;
        default:    w_rdata = 32'h0;
      endcase
    end
  end

  assign Sl_DBus          = w_rdata;
  assign Sl_xferAck       = w_ack;
  assign Sl_errAck        = 1'b0;
  assign Sl_retry         = 1'b0;
  assign Sl_toutSup       = 1'b0;
  assign user_data_out    = r_user_data;
  assign user_data_update = r_update;

endmodule

// File: tb/tb_opb_register_ppc2simulink_sync.sv
// Directed bench for the PPC-to-user OPB control register.
module tb_opb_register_ppc2simulink_sync;

  localparam logic [31:0] DEF    = 32'hA5A5_A5A5;
  localparam logic [31:0] A_DATA = 32'h0108_EC00;
  localparam logic [31:0] A_WCNT = 32'h0108_EC04;
  localparam logic [31:0] A_OTH  = 32'h0108_EC08;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_out;
  logic        user_data_update;

  int n_checks = 0;
  int n_errors = 0;

  // Clock and reset stimulus
  always #5 clk = ~clk;

  opb_register_ppc2simulink_sync #(
    .C_DEFAULT (DEF)
  ) dut (
    .OPB_Clk          (clk),
    .OPB_Rst          (rst),
    .OPB_ABus         (OPB_ABus),
    .OPB_BE           (OPB_BE),
    .OPB_DBus         (OPB_DBus),
    .OPB_RNW          (OPB_RNW),
    .OPB_select       (OPB_select),
    .OPB_seqAddr      (OPB_seqAddr),
    .Sl_DBus          (Sl_DBus),
    .Sl_xferAck       (Sl_xferAck),
    .Sl_errAck        (Sl_errAck),
    .Sl_retry         (Sl_retry),
    .Sl_toutSup       (Sl_toutSup),
    .user_data_out    (user_data_out),
    .user_data_update (user_data_update)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    OPB_select = 1'b0;
    OPB_RNW    = 1'b0;
    OPB_ABus   = 32'h0;
    OPB_DBus   = 32'h0;
    OPB_BE     = 4'b0000;
  endtask

  // One single-beat transfer starting in the current cycle N. Returns the
  // ack-cycle read data, update flags for N+1/N+2/N+3 and user_data_out in N+2.
  task automatic xfer(input string tag, input logic [31:0] addr, input logic rnw,
                      input logic [31:0] wdata, input logic [3:0] be,
                      output logic [31:0] rdata, output logic [2:0] upd,
                      output logic [31:0] udo2);
    OPB_ABus   = addr;
    OPB_RNW    = rnw;
    OPB_DBus   = wdata;
    OPB_BE     = be;
    OPB_select = 1'b1;
    check({tag, " ack_n0"}, 32'(Sl_xferAck), 32'h0);
    check({tag, " dbus_n0"}, Sl_DBus, 32'h0);
    tick();
    check({tag, " ack_n1"}, 32'(Sl_xferAck), 32'h1);
    rdata  = Sl_DBus;
    upd[2] = user_data_update;
    if (!rnw) check({tag, " dbus_wr"}, Sl_DBus, 32'h0);
    bus_idle();
    tick();
    check({tag, " ack_n2"}, 32'(Sl_xferAck), 32'h0);
    check({tag, " dbus_n2"}, Sl_DBus, 32'h0);
    upd[1] = user_data_update;
    udo2   = user_data_out;
    tick();
    upd[0] = user_data_update;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] udo;
    logic [2:0]  upd;
    int          ack_cnt;
    int          first_ack;
    int          last_ack;
    int          upd_cnt;
    int          first_upd;
    int          dbus_nz;

    rst         = 1'b1;
    OPB_seqAddr = 1'b0;
    bus_idle();
    tick(); tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst udo", user_data_out, DEF);
    check("rst upd", 32'(user_data_update), 32'h0);
    check("rst ack", 32'(Sl_xferAck), 32'h0);
    check("rst dbus", Sl_DBus, 32'h0);
    check("rst misc", {29'h0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
    xfer("rd wcnt0", A_WCNT, 1'b1, 32'h0, 4'b0000, rd, upd, udo);
    check("wcnt after reset", rd, 32'h0);
    check("rd no pulse", 32'(upd), 32'h0);

    // Full-word write
    xfer("wr full", A_DATA, 1'b0, 32'h1234_5678, 4'b1111, rd, upd, udo);
    check("wr full udo_n2", udo, 32'h1234_5678);
    check("wr full pulse", 32'(upd), 32'h2);
    xfer("rd wcnt1", A_WCNT, 1'b1, 32'h0, 4'b0000, rd, upd, udo);
    check("wcnt 1", rd, 32'h1);

    // Single byte lane 1
    xfer("wr be0100", A_DATA, 1'b0, 32'hFFFF_FFFF, 4'b0100, rd, upd, udo);
    check("be0100 udo", udo, 32'h12FF_5678);
    check("be0100 pulse", 32'(upd), 32'h2);
    xfer("rd wcnt2", A_WCNT, 1'b1, 32'h0, 4'b0000, rd, upd, udo);
    check("wcnt 2", rd, 32'h2);

    // No byte lanes: acked, no effect
    xfer("wr be0000", A_DATA, 1'b0, 32'h0000_0000, 4'b0000, rd, upd, udo);
    check("be0000 udo", udo, 32'h12FF_5678);
    check("be0000 no pulse", 32'(upd), 32'h0);
    xfer("rd wcnt2b", A_WCNT, 1'b1, 32'h0, 4'b0000, rd, upd, udo);
    check("wcnt still 2", rd, 32'h2);
    xfer("rd data", A_DATA, 1'b1, 32'h0, 4'b0000, rd, upd, udo);
    check("rd data val", rd, 32'h12FF_5678);

    // Unmapped in-window offset
    xfer("wr other", A_OTH, 1'b0, 32'hFFFF_FFFF, 4'b1111, rd, upd, udo);
    check("other udo", udo, 32'h12FF_5678);
    check("other no pulse", 32'(upd), 32'h0);
    xfer("rd other", A_OTH, 1'b1, 32'h0, 4'b0000, rd, upd, udo);
    check("other reads 0", rd, 32'h0);

    // Out-of-window selects
    ack_cnt = 0;
    dbus_nz = 0;
    OPB_select = 1'b1;
    OPB_RNW    = 1'b1;
    OPB_ABus   = 32'h0108_ED00;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (Sl_xferAck) ack_cnt++;
      if (Sl_DBus != 32'h0) dbus_nz++;
    end
    OPB_ABus = 32'h0108_EBFC;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (Sl_xferAck) ack_cnt++;
      if (Sl_DBus != 32'h0) dbus_nz++;
    end
    bus_idle();
    check("nohit acks", 32'(ack_cnt), 32'h0);
    check("nohit dbus", 32'(dbus_nz), 32'h0);
    tick();

    // Back-to-back writes with select held
    ack_cnt = 0; first_ack = -1; last_ack = -1;
    upd_cnt = 0; first_upd = -1;
    OPB_select = 1'b1;
    OPB_RNW    = 1'b0;
    OPB_ABus   = A_DATA;
    OPB_DBus   = 32'hCAFE_F00D;
    OPB_BE     = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      if (Sl_xferAck) begin
        if (first_ack < 0) first_ack = c;
        if (last_ack >= 0 && c - last_ack != 3) begin
          check("b2b spacing", 32'(c - last_ack), 32'h3);
        end
        last_ack = c;
        ack_cnt++;
      end
      if (user_data_update) begin
        if (first_upd < 0) first_upd = c;
        upd_cnt++;
      end
      tick();
    end
    bus_idle();
    if (user_data_update) upd_cnt++;
    check("b2b ack count", 32'(ack_cnt), 32'h4);
    check("b2b first ack", 32'(first_ack), 32'h1);
    check("b2b last ack", 32'(last_ack), 32'hA);
    check("b2b pulses", 32'(upd_cnt), 32'h4);
    check("b2b first pulse", 32'(first_upd), 32'h2);
    tick(); tick();
    check("b2b udo", user_data_out, 32'hCAFE_F00D);
    xfer("rd wcnt6", A_WCNT, 1'b1, 32'h0, 4'b0000, rd, upd, udo);
    check("wcnt 6", rd, 32'h6);

    // Counter wrap
    force dut.r_wcount = 32'hFFFF_FFFF;
    tick();
    release dut.r_wcount;
    tick();
    xfer("rd wcntmax", A_WCNT, 1'b1, 32'h0, 4'b0000, rd, upd, udo);
    check("wcnt max", rd, 32'hFFFF_FFFF);
    xfer("wr wrap", A_DATA, 1'b0, 32'h0F0F_0F0F, 4'b1111, rd, upd, udo);
    check("wrap udo", udo, 32'h0F0F_0F0F);
    xfer("rd wcntwrap", A_WCNT, 1'b1, 32'h0, 4'b0000, rd, upd, udo);
    check("wcnt wrapped", rd, 32'h0);
    xfer("wr be0001", A_DATA, 1'b0, 32'h1111_1111, 4'b0001, rd, upd, udo);
    check("be0001 udo", udo, 32'h0F0F_0F11);
    xfer("rd wcnt1b", A_WCNT, 1'b1, 32'h0, 4'b0000, rd, upd, udo);
    check("wcnt 1 again", rd, 32'h1);

    // Reset during the ack cycle of a write
    OPB_select = 1'b1;
    OPB_RNW    = 1'b0;
    OPB_ABus   = A_DATA;
    OPB_DBus   = 32'hDEAD_BEEF;
    OPB_BE     = 4'b1111;
    tick();
    check("rstmid ack_n1", 32'(Sl_xferAck), 32'h1);
    bus_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid ack", 32'(Sl_xferAck), 32'h0);
    check("rstmid udo", user_data_out, DEF);
    check("rstmid pulse", 32'(user_data_update), 32'h0);
    check("rstmid dbus", Sl_DBus, 32'h0);
    tick();
    check("rstmid pulse late", 32'(user_data_update), 32'h0);
    check("rstmid udo late", user_data_out, DEF);
    xfer("rd wcntrst", A_WCNT, 1'b1, 32'h0, 4'b0000, rd, upd, udo);
    check("wcnt after rstmid", rd, 32'h0);
    xfer("rd datarst", A_DATA, 1'b1, 32'h0, 4'b0000, rd, upd, udo);
    check("data after rstmid", rd, DEF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
